ro_freq_meter: RTL and testbench

RO_FREQ_METER -- requirements
Module: ro_freq_meter

---
 rtl/ro_meas_pkg.sv | 20 ++
 rtl/ro_sync_edge.sv | 26 ++
 rtl/ro_freq_meter.sv | 132 +++++++++++++
 tb/tb_ro_freq_meter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and default widths for the ring-oscillator frequency meter.
package ro_meas_pkg;

  localparam int CNT_W_DEF         = 24;
  localparam int GATE_W_DEF        = 20;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int SEL_W             = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic is_one_hot(input logic [SEL_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for the divided oscillator tap, followed by a
// registered rising-edge pulse (three cycles from input edge to usable pulse).
module ro_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= async_in;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: settles the selected oscillator, then counts
// divided-tap edges over a gate window. Define RO_FREQ_OVF_EN for saturation.
//
// Handshakes: a command transfers on a clock edge where cmd_valid_i && cmd_ready_o;
// a result transfers on an edge where res_valid_o && res_ready_i. Valid is never
// withdrawn without a transfer, except by abort_i or reset.
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_W        = GATE_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [GATE_W-1:0] cmd_gate_i,
  input  logic              abort_i,
  output logic [SEL_W-1:0]  ro_sel_o,
  output logic              ro_start_o,
  input  logic              ro_div_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [CNT_W-1:0]  res_count_o,
  output logic              res_err_o,
  output logic              res_ovf_o,
  output logic [1:0]        dbg_state
);

  localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [GATE_W-1:0]  tmr, gate_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               rise, accept, sel_ok, abort_hit, tmr_zero;

  ro_sync_edge u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .async_in (ro_div_i),
    .rise     (rise)
  );

  assign accept    = (state == ST_IDLE) && cmd_valid_i;
  assign sel_ok    = is_one_hot(cmd_sel_i);
  assign abort_hit = abort_i && (state != ST_IDLE);
  assign tmr_zero  = (tmr == '0);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Abort outranks both the timers and the result handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cmd_valid_i) state_nxt = sel_ok ? ST_SETTLE : ST_DONE;
      ST_SETTLE:  if (abort_i) state_nxt = ST_IDLE;
                  else if (tmr_zero) state_nxt = ST_MEASURE;
      ST_MEASURE: if (abort_i) state_nxt = ST_IDLE;
                  else if (tmr_zero) state_nxt = ST_DONE;
      ST_DONE:    if (abort_i || res_ready_i) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

`ifdef RO_FREQ_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmr    <= '0;
      gate_q <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
`ifdef RO_FREQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      tmr    <= SETTLE_LOAD;
      gate_q <= (cmd_gate_i == '0) ? GATE_W'(1) : cmd_gate_i;
      sel_q  <= sel_ok ? cmd_sel_i : '0;
      cnt_q  <= '0;
      err_q  <= ~sel_ok;
`ifdef RO_FREQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (abort_hit) begin
      sel_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
`ifdef RO_FREQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      // The settle timer reloads with the gate length as MEASURE begins.
      if (state == ST_SETTLE && tmr_zero)
        tmr <= gate_q - 1'b1;
      else if ((state == ST_SETTLE || state == ST_MEASURE) && !tmr_zero)
        tmr <= tmr - 1'b1;
      if (state == ST_MEASURE && rise) begin
`ifdef RO_FREQ_OVF_EN
        if (&cnt_q) ovf_q <= 1'b1;
        else        cnt_q <= cnt_q + 1'b1;
`else
        cnt_q <= cnt_q + 1'b1;
`endif
      end
    end
  end

  assign cmd_ready_o = (state == ST_IDLE);
  assign ro_start_o  = (state == ST_SETTLE) || (state == ST_MEASURE);
  assign ro_sel_o    = ro_start_o ? sel_q : '0;
  assign res_valid_o = (state == ST_DONE);
  assign res_count_o = cnt_q;
  assign res_err_o   = err_q && (state == ST_DONE);
`ifdef RO_FREQ_OVF_EN
  assign res_ovf_o   = ovf_q && (state == ST_DONE);
`else
  assign res_ovf_o   = 1'b0;
`endif
  assign dbg_state   = state;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Self-checking bench for ro_freq_meter: table of measurements plus hand-written
// abort, stall and reset sequences.
module tb_ro_freq_meter;

  localparam int CNT_W  = 4;
  localparam int GATE_W = 20;
  localparam int SETTLE = 16;
  localparam int RW     = CNT_W + 2;
  localparam int BUDGET = 400;

  logic              clk, rst;
  logic              cmd_valid, cmd_ready;
  logic [4:0]        cmd_sel;
  logic [GATE_W-1:0] cmd_gate;
  logic              abort;
  logic [4:0]        ro_sel;
  logic              ro_start;
  logic              ro_div;
  logic              res_valid, res_ready;
  logic [CNT_W-1:0]  res_count;
  logic              res_err, res_ovf;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int half_p   = 0;

  logic [RW-1:0] exp_q[$];

  ro_freq_meter #(.CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYCLES(SETTLE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_sel_i  (cmd_sel),
    .cmd_gate_i (cmd_gate),
    .abort_i    (abort),
    .ro_sel_o   (ro_sel),
    .ro_start_o (ro_start),
    .ro_div_i   (ro_div),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_count_o(res_count),
    .res_err_o  (res_err),
    .res_ovf_o  (res_ovf),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divided oscillator: period 2*half_p cycles, edges on the falling clock.
  initial begin
    ro_div = 1'b0;
    forever begin
      if (half_p == 0) begin
        ro_div = 1'b0;
        @(negedge clk);
      end else begin
        repeat (half_p) @(negedge clk);
        ro_div = ~ro_div;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: present one command for exactly one accepting edge.
  task automatic issue(input logic [4:0] sel, input int gate);
    @(negedge clk);
    check("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_gate  = GATE_W'(gate);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if ($countones(sel) == 1) check("start_after_accept", {ro_start, ro_sel}, {1'b1, sel});
    else                      check("start_after_reject", {ro_start, ro_sel}, 6'b0);
  endtask

  // Waits for res_valid; lat counts edges after the accepting edge.
  task automatic run_measure(input logic [4:0] sel, input int gate, input int half,
                             input logic [CNT_W-1:0] e_cnt, input logic e_err,
                             input logic e_ovf, input int e_lat, input int stall);
    int lat, start_bad, hold_bad;
    bit got;
    logic [RW-1:0] exp;
    half_p = half;
    repeat (10) @(negedge clk);
    issue(sel, gate);
    exp_q.push_back({e_cnt, e_err, e_ovf});
    got = 0;
    start_bad = 0;
    for (lat = 1; lat <= BUDGET; lat++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        got = 1;
        break;
      end
      if (ro_start !== ($countones(sel) == 1)) start_bad++;
    end
    if (!got) begin
      check("result_timeout", 0, 1);
      void'(exp_q.pop_front());
      return;
    end
    check("latency", lat, e_lat);
    check("ro_start_window", start_bad, 0);
    check("done_osc_off", {ro_start, ro_sel, cmd_ready}, 7'b0);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check("result", {res_count, res_err, res_ovf}, exp);
    end
    if (stall > 0) begin
      hold_bad = 0;
      exp = {res_count, res_err, res_ovf};
      repeat (stall) begin
        @(posedge clk);
        #1;
        if (!res_valid || cmd_ready || ({res_count, res_err, res_ovf} !== exp)) hold_bad++;
      end
      check("stall_hold", hold_bad, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("handshake", {res_valid, cmd_ready}, 2'b01);
  endtask

  typedef struct {
    logic [4:0]       sel;
    int               gate;
    int               half;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             ovf;
    int               lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bad;
    vecs[0] = '{5'b00100, 100, 5, 4'd10, 1'b0, 1'b0, SETTLE + 100};
    vecs[1] = '{5'b00001,  40, 2, 4'd10, 1'b0, 1'b0, SETTLE + 40};
    vecs[2] = '{5'b10000,   0, 0, 4'd0,  1'b0, 1'b0, SETTLE + 1};
    vecs[3] = '{5'b00110,  50, 2, 4'd0,  1'b1, 1'b0, 1};
    vecs[4] = '{5'b00000,  50, 2, 4'd0,  1'b1, 1'b0, 1};
    vecs[7] = '{5'b00001,  60, 2, 4'd15, 1'b0, 1'b0, SETTLE + 60};
`ifdef RO_FREQ_OVF_EN
    vecs[5] = '{5'b01000, 100, 2, 4'd15, 1'b0, 1'b1, SETTLE + 100};
    vecs[6] = '{5'b00010,  64, 2, 4'd15, 1'b0, 1'b1, SETTLE + 64};
`else
    vecs[5] = '{5'b01000, 100, 2, 4'd9,  1'b0, 1'b0, SETTLE + 100};
    vecs[6] = '{5'b00010,  64, 2, 4'd0,  1'b0, 1'b0, SETTLE + 64};
`endif

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_sel = '0;
    cmd_gate = '0;
    abort = 1'b0;
    res_ready = 1'b0;
    #2;
    check("reset_outputs", {ro_start, ro_sel, res_valid, res_count, res_err, res_ovf},
          '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ready", {cmd_ready, dbg_state}, 3'b100);

    // Abort while idle must be ignored.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_ignored", {cmd_ready, ro_start, res_valid}, 3'b100);

    for (int i = 0; i < 8; i++)
      run_measure(vecs[i].sel, vecs[i].gate, vecs[i].half, vecs[i].cnt,
                  vecs[i].err, vecs[i].ovf, vecs[i].lat, 0);

    // Abort five cycles into MEASURE: oscillator off next cycle, no result.
    half_p = 5;
    repeat (10) @(negedge clk);
    issue(5'b00100, 100);
    repeat (SETTLE + 5) @(posedge clk);
    #1;
    check("pre_abort_running", {ro_start, dbg_state}, 3'b110);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_outputs", {ro_start, ro_sel, res_valid, cmd_ready}, 8'b00000001);
    bad = 0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (res_valid || !cmd_ready) bad++;
    end
    check("abort_no_result", bad, 0);

    // Result held 50 cycles with res_ready low.
    run_measure(5'b00001, 20, 2, 4'd5, 1'b0, 1'b0, SETTLE + 20, 50);

    // Asynchronous reset in the middle of SETTLE.
    half_p = 5;
    repeat (10) @(negedge clk);
    issue(5'b00100, 100);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          {ro_start, ro_sel, res_valid, res_count, res_err, res_ovf, dbg_state}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_ready", cmd_ready, 1);
    run_measure(5'b00100, 100, 5, 4'd10, 1'b0, 1'b0, SETTLE + 100, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
